test_mailbox_monitor: RTL and testbench

- Synthesizable successor to the bench-side test launcher and checker; it sequences N_TEST self-checking programs on the core.
- Snoops the data-memory write port for the mailbox words: a VALID flag and a RESULT word.
- Holds the core in reset between tests, enforces a per-test cycle timeout, compares the result against an externally supplied expected value, and keeps pass, fail and timeout counters.
- Sits beside the core at top level. It drives the core's reset and observes the mem-access write bus.

---
 rtl/test_mon_pkg.sv | 25 ++
 rtl/mailbox_snoop.sv | 42 ++++
 rtl/test_mailbox_monitor.sv | 174 +++++++++++++++++
 tb/tb_test_mailbox_monitor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_mon_pkg.sv
// Shared types and sizing helpers for the test mailbox monitor.
package test_mon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_CHECK,
    S_NEXT
  } test_mon_state_e;

  localparam int unsigned ADDR_VALID_DEF  = 1;
  localparam int unsigned ADDR_RESULT_DEF = 2;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  // Bits needed to index n items, at least one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mailbox_snoop.sv
// Decodes mailbox writes on the snooped data-memory write port while a test runs.
module mailbox_snoop
  import test_mon_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter int unsigned ADDR_VALID  = ADDR_VALID_DEF,
  parameter int unsigned ADDR_RESULT = ADDR_RESULT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] result,
  output logic          result_seen,
  output logic          complete_c
);

  logic hit_result_c;

  assign hit_result_c = enable && we && (addr == AW'(ADDR_RESULT));
  // Only a VALID write carrying exactly 1 counts as completion.
  assign complete_c   = enable && we && (addr == AW'(ADDR_VALID)) && (wdata == DW'(1));

  // Result latch: last RESULT write of the test wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      result_seen <= 1'b0;
    end else if (clear) begin
      result      <= '0;
      result_seen <= 1'b0;
    end else if (hit_result_c) begin
      result      <= wdata;
      result_seen <= 1'b1;
    end
  end

endmodule

// File: rtl/test_mailbox_monitor.sv
// Sequences N_TEST self-checking programs on the core: reset, run, check, count.
module test_mailbox_monitor
  import test_mon_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter int unsigned N_TEST      = 8,
  parameter int unsigned ADDR_VALID  = ADDR_VALID_DEF,
  parameter int unsigned ADDR_RESULT = ADDR_RESULT_DEF,
  parameter int unsigned TIMEOUT     = 600,
  parameter int unsigned RST_CYCLES  = 2,
  localparam int unsigned IW = idx_width(N_TEST),
  localparam int unsigned CW = cnt_width(N_TEST)
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic [DW-1:0] i_expected,
  output logic          o_core_rst_n,
  output logic [IW-1:0] o_test_idx,
  output logic          o_busy,
  output logic          o_test_done,
  output logic          o_test_pass,
  output logic          o_test_timeout,
  output logic [DW-1:0] o_result,
  output logic          o_run_done,
  output logic [CW-1:0] o_pass_cnt,
  output logic [CW-1:0] o_fail_cnt,
  output logic [CW-1:0] o_tmo_cnt
);

  localparam int unsigned TW = cnt_width(TIMEOUT);
  localparam int unsigned HW = cnt_width(RST_CYCLES);

  test_mon_state_e state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [IW-1:0]   idx_d;
  logic [CW-1:0]   pass_cnt_d, fail_cnt_d, tmo_cnt_d;
  logic [DW-1:0]   result_d;
  logic            done_d, pass_d, timeout_d, run_done_d, core_rst_n_d, busy_d;

  logic [DW-1:0]   snoop_result;
  logic            result_seen;
  logic            complete_c;

  mailbox_snoop #(
    .DW          (DW),
    .AW          (AW),
    .ADDR_VALID  (ADDR_VALID),
    .ADDR_RESULT (ADDR_RESULT)
  ) u_snoop (
    .clk         (i_clk),
    .rst_n       (i_arst_n),
    .clear       (state_q == S_HOLD),
    .enable      (state_q == S_RUN),
    .we          (i_we),
    .addr        (i_addr),
    .wdata       (i_wdata),
    .result      (snoop_result),
    .result_seen (result_seen),
    .complete_c  (complete_c)
  );

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      hold_q         <= '0;
      o_test_idx     <= '0;
      o_pass_cnt     <= '0;
      o_fail_cnt     <= '0;
      o_tmo_cnt      <= '0;
      o_result       <= '0;
      o_test_done    <= 1'b0;
      o_test_pass    <= 1'b0;
      o_test_timeout <= 1'b0;
      o_run_done     <= 1'b0;
      o_core_rst_n   <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      hold_q         <= hold_d;
      o_test_idx     <= idx_d;
      o_pass_cnt     <= pass_cnt_d;
      o_fail_cnt     <= fail_cnt_d;
      o_tmo_cnt      <= tmo_cnt_d;
      o_result       <= result_d;
      o_test_done    <= done_d;
      o_test_pass    <= pass_d;
      o_test_timeout <= timeout_d;
      o_run_done     <= run_done_d;
      o_core_rst_n   <= core_rst_n_d;
      o_busy         <= busy_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    idx_d      = o_test_idx;
    pass_cnt_d = o_pass_cnt;
    fail_cnt_d = o_fail_cnt;
    tmo_cnt_d  = o_tmo_cnt;
    result_d   = o_result;
    done_d     = 1'b0;
    pass_d     = o_test_pass;
    timeout_d  = o_test_timeout;
    run_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          tmo_cnt_d  = '0;
          idx_d      = '0;
          hold_d     = '0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == HW'(RST_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_RUN: begin
        timer_d = timer_q + TW'(1);
        // Completion takes priority over a timeout in the same cycle.
        if (complete_c || (timer_q == TW'(TIMEOUT - 1))) begin
          state_d   = S_CHECK;
          done_d    = 1'b1;
          timeout_d = !complete_c;
          pass_d    = complete_c && result_seen && (snoop_result == i_expected);
          result_d  = snoop_result;
          if (pass_d) begin
            if (o_pass_cnt != CW'(N_TEST)) pass_cnt_d = o_pass_cnt + CW'(1);
          end else begin
            if (o_fail_cnt != CW'(N_TEST)) fail_cnt_d = o_fail_cnt + CW'(1);
          end
          if (timeout_d && (o_tmo_cnt != CW'(N_TEST))) tmo_cnt_d = o_tmo_cnt + CW'(1);
        end
      end
      S_CHECK: begin
        state_d    = S_NEXT;
        run_done_d = (o_test_idx == IW'(N_TEST - 1));
      end
      S_NEXT: begin
        if (o_test_idx == IW'(N_TEST - 1)) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = o_test_idx + IW'(1);
          hold_d  = '0;
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    core_rst_n_d = (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_test_mailbox_monitor.sv
// Randomized scoreboard bench for test_mailbox_monitor.
module tb_test_mailbox_monitor;

  localparam int unsigned DW         = 32;
  localparam int unsigned AW         = 32;
  localparam int unsigned N_TEST     = 4;
  localparam int unsigned TIMEOUT    = 20;
  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned A_VALID    = 1;
  localparam int unsigned A_RESULT   = 2;
  localparam int unsigned IW         = 2;
  localparam int unsigned CW         = 3;

  typedef enum int {SC_PASS, SC_FAIL, SC_TMO, SC_NORES, SC_MULTI, SC_EDGE} scen_e;

  typedef struct {
    bit            pass;
    bit            tmo;
    logic [DW-1:0] res;
    int            idx;
    int            cyc;
    int            pc;
    int            fc;
    int            tc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] expected = '0;

  logic          o_core_rst_n, o_busy, o_test_done, o_test_pass, o_test_timeout, o_run_done;
  logic [IW-1:0] o_test_idx;
  logic [DW-1:0] o_result;
  logic [CW-1:0] o_pass_cnt, o_fail_cnt, o_tmo_cnt;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_done = -1;
  int   m_pass, m_fail, m_tmo;
  exp_t sb[$];

  test_mailbox_monitor #(
    .DW(DW), .AW(AW), .N_TEST(N_TEST), .ADDR_VALID(A_VALID), .ADDR_RESULT(A_RESULT),
    .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_start(start), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_expected(expected), .o_core_rst_n(o_core_rst_n),
    .o_test_idx(o_test_idx), .o_busy(o_busy), .o_test_done(o_test_done),
    .o_test_pass(o_test_pass), .o_test_timeout(o_test_timeout), .o_result(o_result),
    .o_run_done(o_run_done), .o_pass_cnt(o_pass_cnt), .o_fail_cnt(o_fail_cnt),
    .o_tmo_cnt(o_tmo_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every test_done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_test_done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("done_idx", 64'(o_test_idx), 64'(e.idx));
        chk("done_pass", 64'(o_test_pass), 64'(e.pass));
        chk("done_timeout", 64'(o_test_timeout), 64'(e.tmo));
        chk("done_result", 64'(o_result), 64'(e.res));
        chk("pass_cnt", 64'(o_pass_cnt), 64'(e.pc));
        chk("fail_cnt", 64'(o_fail_cnt), 64'(e.fc));
        chk("tmo_cnt", 64'(o_tmo_cnt), 64'(e.tc));
        last_done = cyc;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_core_rst_n"}, 64'(o_core_rst_n), 64'(0));
    chk({tag, "_idx"}, 64'(o_test_idx), 64'(0));
    chk({tag, "_busy"}, 64'(o_busy), 64'(0));
    chk({tag, "_done"}, 64'(o_test_done), 64'(0));
    chk({tag, "_pass"}, 64'(o_test_pass), 64'(0));
    chk({tag, "_timeout"}, 64'(o_test_timeout), 64'(0));
    chk({tag, "_result"}, 64'(o_result), 64'(0));
    chk({tag, "_run_done"}, 64'(o_run_done), 64'(0));
    chk({tag, "_cnts"}, {o_pass_cnt, o_fail_cnt, o_tmo_cnt}, 64'(0));
  endtask

  task automatic idle_bus();
    we    = 1'b0;
    addr  = AW'($urandom_range(0, 9));
    wdata = ($urandom_range(0, 1) == 1) ? DW'(1) : DW'($urandom);
  endtask

  task automatic write(input int unsigned a, input logic [DW-1:0] d);
    we    = 1'b1;
    addr  = AW'(a);
    wdata = d;
  endtask

  task automatic wait_release(output int r, output bit ok);
    ok = 1'b0;
    r  = 0;
    for (int i = 0; i < int'(TIMEOUT) + 20 && o_core_rst_n; i++) @(negedge clk);
    for (int i = 0; i < int'(TIMEOUT) + 20; i++) begin
      if (o_core_rst_n) begin
        ok = 1'b1;
        r  = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  // One test: plan the mailbox traffic, predict the verdict, then drive it.
  task automatic run_test(input int idx, input scen_e sc, input int start_cyc, input bit abort);
    int r, kv, kr1, kr2, kb;
    bit ok, has_r1, has_r2, has_bad, seen, tmo, pass;
    logic [DW-1:0] v1, v2, res, exp_val;
    exp_t e;

    wait_release(r, ok);
    chk("release_seen", 64'(ok), 64'(1));
    if (!ok) return;
    if (idx == 0) chk("release_lat_first", 64'(r - start_cyc), 64'(RST_CYCLES + 1));
    else          chk("release_lat_next", 64'(r - last_done), 64'(RST_CYCLES + 2));

    kr1 = $urandom_range(0, 4);
    kr2 = $urandom_range(5, 9);
    kb  = $urandom_range(0, 4);
    kv  = $urandom_range(10, TIMEOUT - 2);
    v1  = $urandom;
    v2  = $urandom;
    has_r1  = (sc != SC_NORES);
    has_r2  = (sc == SC_MULTI);
    has_bad = (sc == SC_NORES) || ($urandom_range(0, 1) == 1);
    if (sc == SC_EDGE) kv = TIMEOUT - 1;
    if (sc == SC_TMO) kv = -1;
    if (sc == SC_MULTI) begin
      v1 = 3;
      v2 = 'h3f8;
    end

    seen = has_r1;
    res  = has_r2 ? v2 : (has_r1 ? v1 : '0);
    case (sc)
      SC_FAIL:  exp_val = res + 1;
      SC_NORES: exp_val = '0;
      default:  exp_val = res;
    endcase
    tmo  = (kv < 0);
    pass = !tmo && seen && (res == exp_val);
    if (pass) m_pass++; else m_fail++;
    if (tmo) m_tmo++;
    e.pass = pass;
    e.tmo  = tmo;
    e.res  = res;
    e.idx  = idx;
    e.cyc  = tmo ? r + int'(TIMEOUT) : r + kv + 1;
    e.pc   = (m_pass > int'(N_TEST)) ? int'(N_TEST) : m_pass;
    e.fc   = (m_fail > int'(N_TEST)) ? int'(N_TEST) : m_fail;
    e.tc   = (m_tmo > int'(N_TEST)) ? int'(N_TEST) : m_tmo;
    sb.push_back(e);

    expected = exp_val;
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      idle_bus();
      start = 1'b0;
      if (abort && k == 5) begin
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        sb.delete();
        we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_busy", 64'(o_busy), 64'(0));
        return;
      end
      if (has_r1 && k == kr1)        write(A_RESULT, v1);
      else if (has_r2 && k == kr2) begin
        write(A_RESULT, v2);
        start = 1'b1;
      end
      else if (has_bad && k == kb)   write(A_VALID, DW'(2));
      else if (k == kv)              write(A_VALID, DW'(1));
      else if ($urandom_range(0, 3) == 0) write($urandom_range(3, 9), DW'(1));
      @(negedge clk);
      if (k == kv) break;
    end
    idle_bus();
    start = 1'b0;
  endtask

  function automatic scen_e pick(input int mode, input int j);
    case (mode)
      0:       return scen_e'(j);
      1, 2:    return (j == 0) ? SC_MULTI : (j == 1) ? SC_EDGE : scen_e'($urandom_range(0, 5));
      default: return scen_e'($urandom_range(0, 5));
    endcase
  endfunction

  task automatic do_run(input int mode, input int abort_idx);
    int s;
    m_pass = 0;
    m_fail = 0;
    m_tmo  = 0;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 64'(o_busy), 64'(1));
    chk("start_idx", 64'(o_test_idx), 64'(0));
    chk("start_cnts_clear", {o_pass_cnt, o_fail_cnt, o_tmo_cnt}, 64'(0));
    chk("start_core_rst", 64'(o_core_rst_n), 64'(0));
    for (int j = 0; j < int'(N_TEST); j++) begin
      run_test(j, pick(mode, j), s, j == abort_idx);
      if (j == abort_idx) return;
    end
    for (int i = 0; i < 10 && !o_run_done; i++) @(negedge clk);
    chk("run_done_seen", 64'(o_run_done), 64'(1));
    chk("run_done_cycle", 64'(cyc - last_done), 64'(1));
    chk("final_idx", 64'(o_test_idx), 64'(N_TEST - 1));
    chk("final_pass_cnt", 64'(o_pass_cnt), 64'(m_pass));
    chk("final_fail_cnt", 64'(o_fail_cnt), 64'(m_fail));
    chk("final_tmo_cnt", 64'(o_tmo_cnt), 64'(m_tmo));
    @(negedge clk);
    chk("after_run_busy", 64'(o_busy), 64'(0));
    chk("after_run_pulse", 64'(o_run_done), 64'(0));
    chk("after_run_idx", 64'(o_test_idx), 64'(N_TEST - 1));
    chk("after_run_core_rst", 64'(o_core_rst_n), 64'(0));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");
    do_run(0, -1);
    do_run(1, 1);
    repeat (2) @(negedge clk);
    do_run(2, -1);
    do_run(3, -1);
    do_run(3, -1);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of bench by %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
